// File: rtl/armv4_defs.sv
// Shared definitions for the ARMv4 block-transfer logic.
// Contents: sequencer state encoding, the PC register code and the
// word step used for address arithmetic.
package armv4_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_WBASE = 2'd2
  } state_t;

  localparam logic [3:0]  PC_CODE   = 4'd15;
  localparam logic [31:0] WORD_STEP = 32'd4;

endpackage

// File: rtl/ldm_regsel.sv
// Register-list helper (purely combinational).
// Ports:
//   vec     in  16 : register list / remaining mask
//   low_idx out 4  : index of the lowest set bit (0 when vec is empty)
//   low_vld out 1  : vec has at least one bit set
//   count   out 5  : number of set bits in vec
module ldm_regsel (
  input  logic [15:0] vec,
  output logic [3:0]  low_idx,
  output logic        low_vld,
  output logic [4:0]  count
);

  always_comb begin
    low_idx = '0;
    low_vld = 1'b0;
    count   = '0;
    // Scan downwards so the last hit is the lowest set bit.
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) begin
        low_idx = 4'(i);
        low_vld = 1'b1;
      end
    end
    for (int i = 0; i < 16; i++) begin
      count = count + {4'b0, vec[i]};
    end
  end

endmodule

// File: rtl/ldm_seq.sv
// LDM/STM block-transfer sequencer for the execute stage.
// Breaks one decoded block transfer into single-word memory beats,
// lowest-numbered register first, then issues the base writeback.
// Optional feature macro: ARMV4_LDM_USER_BANK_EN (adds i_sbit / o_user_bank).
// Ports:
//   i_clk, i_rst          : clock, asynchronous active-high reset
//   i_start..i_base       : decoded instruction fields and base value
//   i_flush               : synchronous abort
//   i_mem_rdy/i_mem_rdata : memory handshake and load data
//   o_ldm_hold            : pipeline-hold request (combinational)
//   o_mem_*/o_st_code     : beat presented to memory
//   o_rd_*                : registered load-register write
//   o_base_wb_*           : base register writeback
//   o_user_bank           : beat uses user-mode registers (macro only)
module ldm_seq
  import armv4_defs::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_load,
  input  logic        i_pre,
  input  logic        i_up,
  input  logic        i_wb,
  input  logic [15:0] i_reglist,
  input  logic [3:0]  i_rn_code,
  input  logic [31:0] i_base,
  input  logic        i_flush,
  input  logic        i_mem_rdy,
  input  logic [31:0] i_mem_rdata,
`ifdef ARMV4_LDM_USER_BANK_EN
  input  logic        i_sbit,
  output logic        o_user_bank,
`endif
  output logic        o_ldm_hold,
  output logic        o_mem_vld,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_st_code,
  output logic        o_rd_vld,
  output logic [3:0]  o_rd_code,
  output logic [31:0] o_rd_data,
  output logic        o_base_wb_vld,
  output logic [3:0]  o_base_wb_code,
  output logic [31:0] o_base_wb_data
);

  state_t      state_reg, state_next;
  logic [15:0] mask_reg, mask_next;
  logic        load_reg, load_next;
  logic        wb_en_reg, wb_en_next;
  logic [3:0]  rn_reg, rn_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wb_data_reg, wb_data_next;
  logic        rd_vld_reg, rd_vld_next;
  logic [3:0]  rd_code_reg, rd_code_next;
  logic [31:0] rd_data_reg, rd_data_next;
`ifdef ARMV4_LDM_USER_BANK_EN
  logic        user_reg, user_next;
`endif

  logic        list_nz;
  logic [4:0]  list_cnt;
  logic [3:0]  unused_list_low;
  logic [3:0]  cur_code;
  logic [4:0]  mask_cnt;
  logic        unused_mask_vld;

  ldm_regsel u_list_sel (
    .vec     (i_reglist),
    .low_idx (unused_list_low),
    .low_vld (list_nz),
    .count   (list_cnt)
  );

  ldm_regsel u_mask_sel (
    .vec     (mask_reg),
    .low_idx (cur_code),
    .low_vld (unused_mask_vld),
    .count   (mask_cnt)
  );

  logic [31:0] step4n;
  logic [31:0] start_addr;
  logic        in_xfer, in_wbase, in_idle;

  assign step4n   = {25'b0, list_cnt, 2'b00};
  assign in_idle  = (state_reg == ST_IDLE);
  assign in_xfer  = (state_reg == ST_XFER);
  assign in_wbase = (state_reg == ST_WBASE);

  // Lowest word of the block by addressing mode; beats always ascend.
  always_comb begin
    case ({i_pre, i_up})
      2'b01:   start_addr = i_base;                        // IA
      2'b11:   start_addr = i_base + WORD_STEP;            // IB
      2'b00:   start_addr = i_base - step4n + WORD_STEP;   // DA
      default: start_addr = i_base - step4n;               // DB
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    mask_next    = mask_reg;
    load_next    = load_reg;
    wb_en_next   = wb_en_reg;
    rn_next      = rn_reg;
    addr_next    = addr_reg;
    wb_data_next = wb_data_reg;
    rd_vld_next  = 1'b0;
    rd_code_next = rd_code_reg;
    rd_data_next = rd_data_reg;
`ifdef ARMV4_LDM_USER_BANK_EN
    user_next    = user_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (i_start && list_nz && !i_flush) begin
          state_next   = ST_XFER;
          mask_next    = i_reglist;
          load_next    = i_load;
          // A load that overwrites the base keeps the loaded value.
          wb_en_next   = i_wb && !(i_load && i_reglist[i_rn_code]);
          rn_next      = i_rn_code;
          addr_next    = start_addr;
          wb_data_next = i_up ? (i_base + step4n) : (i_base - step4n);
`ifdef ARMV4_LDM_USER_BANK_EN
          // LDM with r15 in the list is an exception return, not a
          // user-bank transfer.
          user_next    = i_sbit && (!i_load || !i_reglist[PC_CODE]);
`endif
        end
      end
      ST_XFER: begin
        if (i_flush) begin
          state_next = ST_IDLE;
          mask_next  = '0;
        end else if (i_mem_rdy) begin
          mask_next    = mask_reg & ~(16'd1 << cur_code);
          addr_next    = addr_reg + WORD_STEP;
          rd_vld_next  = load_reg;
          rd_code_next = cur_code;
          rd_data_next = i_mem_rdata;
          if (mask_cnt == 5'd1) begin
            state_next = wb_en_reg ? ST_WBASE : ST_IDLE;
          end
        end
      end
      ST_WBASE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        mask_next  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg   <= ST_IDLE;
      mask_reg    <= '0;
      load_reg    <= 1'b0;
      wb_en_reg   <= 1'b0;
      rn_reg      <= '0;
      addr_reg    <= '0;
      wb_data_reg <= '0;
      rd_vld_reg  <= 1'b0;
      rd_code_reg <= '0;
      rd_data_reg <= '0;
`ifdef ARMV4_LDM_USER_BANK_EN
      user_reg    <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      mask_reg    <= mask_next;
      load_reg    <= load_next;
      wb_en_reg   <= wb_en_next;
      rn_reg      <= rn_next;
      addr_reg    <= addr_next;
      wb_data_reg <= wb_data_next;
      rd_vld_reg  <= rd_vld_next;
      rd_code_reg <= rd_code_next;
      rd_data_reg <= rd_data_next;
`ifdef ARMV4_LDM_USER_BANK_EN
      user_reg    <= user_next;
`endif
    end
  end

  assign o_ldm_hold     = (i_start && in_idle) || !in_idle;
  assign o_mem_vld      = in_xfer;
  assign o_mem_we       = in_xfer && !load_reg;
  assign o_mem_addr     = in_xfer ? addr_reg : '0;
  assign o_st_code      = (in_xfer && !load_reg) ? cur_code : '0;
  assign o_rd_vld       = rd_vld_reg;
  assign o_rd_code      = rd_code_reg;
  assign o_rd_data      = rd_data_reg;
  assign o_base_wb_vld  = in_wbase && !i_flush;
  assign o_base_wb_code = in_wbase ? rn_reg : '0;
  assign o_base_wb_data = in_wbase ? wb_data_reg : '0;
`ifdef ARMV4_LDM_USER_BANK_EN
  assign o_user_bank    = in_xfer && user_reg;
`endif

endmodule

// File: tb/tb_ldm_seq.sv
// Self-checking bench for ldm_seq: directed test-plan transfers plus
// randomized transfers, checked against a block-transfer model that
// derives beat addresses and register order from the instruction fields.
module tb_ldm_seq;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_start = 1'b0, i_load = 1'b0, i_pre = 1'b0, i_up = 1'b0, i_wb = 1'b0;
  logic [15:0] i_reglist = '0;
  logic [3:0]  i_rn_code = '0;
  logic [31:0] i_base = '0;
  logic        i_flush = 1'b0, i_mem_rdy = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic        i_sbit = 1'b0;
  logic        o_user_bank;
  logic        o_ldm_hold, o_mem_vld, o_mem_we, o_rd_vld, o_base_wb_vld;
  logic [31:0] o_mem_addr, o_rd_data, o_base_wb_data;
  logic [3:0]  o_st_code, o_rd_code, o_base_wb_code;

  int checks = 0;
  int errors = 0;

  ldm_seq dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_load(i_load),
    .i_pre(i_pre), .i_up(i_up), .i_wb(i_wb), .i_reglist(i_reglist),
    .i_rn_code(i_rn_code), .i_base(i_base), .i_flush(i_flush),
    .i_mem_rdy(i_mem_rdy), .i_mem_rdata(i_mem_rdata),
`ifdef ARMV4_LDM_USER_BANK_EN
    .i_sbit(i_sbit), .o_user_bank(o_user_bank),
`endif
    .o_ldm_hold(o_ldm_hold), .o_mem_vld(o_mem_vld), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_st_code(o_st_code), .o_rd_vld(o_rd_vld),
    .o_rd_code(o_rd_code), .o_rd_data(o_rd_data),
    .o_base_wb_vld(o_base_wb_vld), .o_base_wb_code(o_base_wb_code),
    .o_base_wb_data(o_base_wb_data)
  );

`ifndef ARMV4_LDM_USER_BANK_EN
  assign o_user_bank = 1'b0;
`endif

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    i_start = 1'b0; i_flush = 1'b0; i_mem_rdy = 1'b0; i_mem_rdata = $urandom;
  endtask

  // One block transfer. stall_beat/stall_len give a directed wait-state
  // burst, rand_stall adds random wait states on every beat, flush_beat
  // aborts on the acceptance of that beat (-1: never).
  task automatic do_xfer(input bit l, input bit p, input bit u, input bit w,
                         input bit s, input logic [15:0] list,
                         input logic [3:0] rn, input logic [31:0] base,
                         input int stall_beat, input int stall_len,
                         input bit rand_stall, input int flush_beat);
    int regs[$];
    int n, stalls, xfer_cycles, hold_cnt, hold_exp;
    logic [31:0] lo, wbv, rd_d;
    logic [3:0] rd_c;
    bit wb_exp, rd_p, flushed, acc, ub_exp;
    for (int i = 0; i < 16; i++) if (list[i]) regs.push_back(i);
    n = regs.size();
    // Occupied block [lo, lo+4n) follows from the addressing mode.
    if (u) lo = base + (p ? 32'd4 : 32'd0);
    else   lo = base - 32'(4 * n) + (p ? 32'd0 : 32'd4);
    wbv    = u ? base + 32'(4 * n) : base - 32'(4 * n);
    wb_exp = w && !(l && list[rn]);
    ub_exp = s && (!l || !list[15]);
    hold_cnt = 0; xfer_cycles = 0; rd_p = 1'b0; rd_c = '0; rd_d = '0; flushed = 1'b0;

    @(negedge i_clk);
    i_start = 1'b1; i_load = l; i_pre = p; i_up = u; i_wb = w; i_sbit = s;
    i_reglist = list; i_rn_code = rn; i_base = base;
    i_flush = 1'b0; i_mem_rdy = 1'b1;
    #1;
    chk("hold_start", {31'b0, o_ldm_hold}, 1);
    chk("vld_start", {31'b0, o_mem_vld}, 0);
    hold_cnt += int'(o_ldm_hold);

    for (int k = 0; k < n && !flushed; k++) begin
      stalls = rand_stall ? int'($urandom_range(0, 2)) : (k == stall_beat ? stall_len : 0);
      for (int c = 0; c <= stalls; c++) begin
        @(negedge i_clk);
        acc = (c == stalls);
        i_mem_rdy = acc;
        i_mem_rdata = $urandom;
        i_flush = acc && (k == flush_beat);
        // New instructions must be ignored while busy.
        i_start = 1'($urandom_range(0, 1));
        i_reglist = 16'($urandom);
        i_base = $urandom;
        #1;
        chk("beat_vld", {31'b0, o_mem_vld}, 1);
        chk("beat_addr", o_mem_addr, lo + 32'(4 * k));
        chk("beat_we", {31'b0, o_mem_we}, {31'b0, !l});
        if (!l) chk("beat_st_code", {28'b0, o_st_code}, regs[k]);
        chk("beat_hold", {31'b0, o_ldm_hold}, 1);
        chk("beat_rd_vld", {31'b0, o_rd_vld}, {31'b0, rd_p});
        if (rd_p) begin
          chk("beat_rd_code", {28'b0, o_rd_code}, {28'b0, rd_c});
          chk("beat_rd_data", o_rd_data, rd_d);
        end
`ifdef ARMV4_LDM_USER_BANK_EN
        chk("beat_user", {31'b0, o_user_bank}, {31'b0, ub_exp});
`endif
        chk("beat_no_wb", {31'b0, o_base_wb_vld}, 0);
        hold_cnt += int'(o_ldm_hold);
        xfer_cycles++;
        rd_p = acc && l && !i_flush;
        rd_c = 4'(regs[k]);
        rd_d = i_mem_rdata;
        if (acc && i_flush) flushed = 1'b1;
      end
    end

    if (n == 0) begin
      @(negedge i_clk); drive_idle(); #1;
      chk("empty_hold", {31'b0, o_ldm_hold}, 0);
      chk("empty_vld", {31'b0, o_mem_vld}, 0);
      chk("empty_wb", {31'b0, o_base_wb_vld}, 0);
      hold_exp = 1;
    end else if (flushed) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge i_clk); drive_idle(); #1;
        chk("flush_hold", {31'b0, o_ldm_hold}, 0);
        chk("flush_vld", {31'b0, o_mem_vld}, 0);
        chk("flush_rd_vld", {31'b0, o_rd_vld}, 0);
        chk("flush_wb", {31'b0, o_base_wb_vld}, 0);
      end
      hold_exp = 1 + xfer_cycles;
    end else begin
      if (wb_exp) begin
        @(negedge i_clk); drive_idle(); #1;
        chk("wb_vld", {31'b0, o_base_wb_vld}, 1);
        chk("wb_code", {28'b0, o_base_wb_code}, {28'b0, rn});
        chk("wb_data", o_base_wb_data, wbv);
        chk("wb_hold", {31'b0, o_ldm_hold}, 1);
        chk("wb_mem_vld", {31'b0, o_mem_vld}, 0);
        chk("wb_rd_vld", {31'b0, o_rd_vld}, {31'b0, rd_p});
        if (rd_p) chk("wb_rd_data", o_rd_data, rd_d);
        hold_cnt += int'(o_ldm_hold);
        rd_p = 1'b0;
      end
      @(negedge i_clk); drive_idle(); #1;
      chk("end_hold", {31'b0, o_ldm_hold}, 0);
      chk("end_vld", {31'b0, o_mem_vld}, 0);
      chk("end_wb", {31'b0, o_base_wb_vld}, 0);
      chk("end_rd_vld", {31'b0, o_rd_vld}, {31'b0, rd_p});
      if (rd_p) begin
        chk("end_rd_code", {28'b0, o_rd_code}, {28'b0, rd_c});
        chk("end_rd_data", o_rd_data, rd_d);
      end
      hold_exp = 1 + xfer_cycles + int'(wb_exp);
    end
    chk("hold_total", 32'(hold_cnt), 32'(hold_exp));
    @(negedge i_clk); drive_idle();
    $display("xfer L=%0d P=%0d U=%0d W=%0d list=%04h rn=%0d base=%08h beats=%0d hold=%0d flush=%0d",
             l, p, u, w, list, rn, base, n, hold_cnt, flushed);
  endtask

  initial begin
    // Asynchronous reset before any clock edge.
    #2 i_rst = 1'b1;
    #1;
    chk("rst_hold", {31'b0, o_ldm_hold}, 0);
    chk("rst_vld", {31'b0, o_mem_vld}, 0);
    chk("rst_rd_vld", {31'b0, o_rd_vld}, 0);
    chk("rst_rd_data", o_rd_data, 0);
    chk("rst_wb_vld", {31'b0, o_base_wb_vld}, 0);
    chk("rst_addr", o_mem_addr, 0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;

    // LDMIA r0!, {r1-r3}
    do_xfer(1, 0, 1, 1, 0, 16'h000E, 4'd0, 32'h0000_1000, -1, 0, 0, -1);
    // STMDB with writeback, {r0,r1,r14}
    do_xfer(0, 1, 0, 1, 0, 16'h4003, 4'd13, 32'h0000_2000, -1, 0, 0, -1);
    // LDMIB r2!, list contains r2: no base writeback
    do_xfer(1, 1, 1, 1, 0, 16'h0034, 4'd2, 32'h0000_3000, -1, 0, 0, -1);
    // DA wrap-around below zero
    do_xfer(0, 0, 0, 1, 0, 16'h0007, 4'd5, 32'h0000_0004, -1, 0, 0, -1);
    // Two wait states on the second beat, including r15 load
    do_xfer(1, 0, 1, 0, 0, 16'h8006, 4'd0, 32'h0000_5000, 1, 2, 0, -1);
    // Flush on the second beat
    do_xfer(1, 0, 1, 1, 0, 16'h00F0, 4'd1, 32'h0000_6000, -1, 0, 0, 1);
    // Empty list
    do_xfer(1, 0, 1, 1, 0, 16'h0000, 4'd3, 32'h0000_7000, -1, 0, 0, -1);
    // User-bank store and exception-return style load
    do_xfer(0, 0, 1, 0, 1, 16'h8001, 4'd4, 32'h0000_8000, -1, 0, 0, -1);
    do_xfer(1, 0, 1, 0, 1, 16'h8001, 4'd4, 32'h0000_8000, -1, 0, 0, -1);

    for (int t = 0; t < 25; t++) begin
      logic [15:0] lst;
      int fb;
      lst = 16'($urandom);
      if (t % 7 == 3) lst = 16'd0;
      fb = (t % 5 == 2) ? int'($urandom_range(0, 3)) : -1;
      do_xfer(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              lst, 4'($urandom), $urandom, -1, 0, 1, fb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ldm_seq.md
# ldm_seq

Block-transfer sequencer for LDM/STM in the execute stage. It accepts one decoded block-transfer instruction and breaks it into single-word memory beats, lowest-numbered register first. It drives the per-register writes and the base-register writeback. While a transfer is in progress it raises the pipeline-hold request (`o_ldm_hold`) that the hazard controller merges into its pipeline hold and EX flush.

## Interface
- No parameters; data width fixed at 32, register codes 4 bits.
- `i_clk` in 1: core clock, rising edge.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_start` in 1: EX holds a valid LDM/STM this cycle.
- `i_load` in 1: L bit (1 = LDM, 0 = STM).
- `i_pre` in 1: P bit.
- `i_up` in 1: U bit.
- `i_wb` in 1: W bit.
- `i_reglist` in 16: register list.
- `i_rn_code` in 4: base register code.
- `i_base` in 32: base register value.
- `i_flush` in 1: synchronous abort.
- `i_mem_rdy` in 1: memory accepts the presented beat this cycle.
- `i_mem_rdata` in 32: load data, valid with `i_mem_rdy`.
- `o_ldm_hold` out 1: pipeline-hold request to the hazard controller.
- `o_mem_vld` out 1: beat presented.
- `o_mem_we` out 1: store beat.
- `o_mem_addr` out 32: word address of the beat.
- `o_st_code` out 4: register to read for the store beat.
- `o_rd_vld` out 1: load register write.
- `o_rd_code` out 4: load register code.
- `o_rd_data` out 32: load register data.
- `o_base_wb_vld` out 1: base writeback.
- `o_base_wb_code` out 4: base register code for the writeback.
- `o_base_wb_data` out 32: base writeback value.
- `o_user_bank` out 1: beat uses user-mode registers; present only under the macro in Configuration.

## Operation
- States: IDLE, XFER, WBASE.
- IDLE → XFER: `i_start` with a non-empty list. Latch L/P/U/W, the list (as the remaining mask), Rn, n = popcount(list), start address and writeback value.
- Start address by mode:
  - IA: base.
  - IB: base+4.
  - DA: base−4n+4.
  - DB: base−4n.
- Writeback value: U ? base+4n : base−4n (mod 2^32).
- XFER beat:
  - `o_mem_vld`=1, `o_mem_addr` = current address, register = lowest set bit of the remaining mask.
  - On `i_mem_rdy`: clear that bit and add 4 to the address.
  - When the accepted bit was the last one: go to WBASE if writeback is enabled, else IDLE.
- Writeback enabled = W && !(L && list[Rn]). On LDM with Rn in the list, the loaded value wins and no base writeback is issued.
- WBASE: one cycle of `o_base_wb_vld`, then IDLE.
- Empty list with `i_start`: stay IDLE, no beats, no writeback, `o_ldm_hold` asserted only in that cycle.
- Loading r15 produces `o_rd_code`=15 like any other register. PC redirect is handled downstream.
- `i_start` is ignored outside IDLE.
- `i_flush`: go to IDLE next cycle and clear `o_rd_vld`, `o_base_wb_vld` and the remaining mask. A beat already accepted in the same cycle still has its load write dropped.

## Timing
- Reset values: state IDLE, mask 0, every output 0.
- `o_ldm_hold` = (`i_start` && IDLE) || state≠IDLE. This is combinational, so the hold is seen in the start cycle itself.
- First beat is presented the cycle after `i_start`.
- Throughput: one beat per cycle while `i_mem_rdy`=1. Wait states simply hold the beat unchanged.
- Load write: `o_rd_vld/code/data` are registered and asserted the cycle after each accepted load beat. The last one coincides with WBASE or the first IDLE cycle.
- Total hold length = 1 + (cycles spent in XFER) + (1 if WBASE).
- Address arithmetic is 32-bit and wraps modulo 2^32; no fault is raised.

## Configuration
- `ARMV4_LDM_USER_BANK_EN` defined:
  - Adds input `i_sbit` and output `o_user_bank`.
  - `o_user_bank` = latched S && (STM || r15 ∉ list), asserted with each beat.
- Undefined:
  - Neither port exists; the S bit is ignored and all transfers use the current bank.

## Structure
- Shared package/header `armv4_defs`: state encoding (IDLE/XFER/WBASE), the PC register code 15, and a word-step constant of 4.
- Sub-module `ldm_regsel` (combinational): lowest-set-bit encoder and 16-bit popcount. It is instantiated twice: popcount of `i_reglist`, and lowest-set-bit of the remaining mask.

## Test plan
- LDMIA base=0x1000, list=0x000E (r1–r3), W=1, Rn=r0, rdy always 1:
  - Addresses 0x1000/0x1004/0x1008.
  - `o_rd_code` 1,2,3 one cycle after each beat.
  - `o_base_wb_data`=0x100C.
  - Hold high for 5 cycles.
- STMDB base=0x2000, list=0x4003 (r0,r1,r14), W=1:
  - Addresses 0x1FF4/0x1FF8/0x1FFC.
  - `o_st_code` 0,1,14, `o_mem_we`=1.
  - Writeback 0x1FF4.
- LDMIB base=0x3000, list includes Rn=r2, W=1:
  - First address 0x3004, r2 loaded.
  - No `o_base_wb_vld`.
- DA mode at base=0x4 with n=3: first address 0xFFFFFFFC, wrap-around checked.
- `i_mem_rdy` low 2 cycles on the second beat: address and code stable, hold extended by 2.
- Abort and empty-list cases:
  - `i_flush` mid-transfer: IDLE next cycle, no further beats or writeback.
  - Empty list: single-cycle hold, no beats.
